program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 188 ++++++++++++++++++
 tb/tb_program_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//   Receives a program over a byte stream and writes it into instruction
//   memory one 32-bit word at a time, then releases the core once the stream
//   checksum has been verified.
//
//   Stream: count byte N (1..WORDS), 4*N data bytes (little-endian per word),
//           one checksum byte = XOR of all data bytes.
//
// Ports
//   CLK            clock, all state updates on the rising edge
//   RST            synchronous active-high reset (priority over START)
//   START          pulse: begin a new load (honoured in IDLE, RUN, FAIL)
//   RX_DATA[7:0]   incoming byte
//   RX_VALID       RX_DATA valid; held by the source until accepted
//   RX_READY       loader accepts a byte this cycle
//   W_EN           instruction-memory write strobe (one cycle per word)
//   W_INSTRUCTION  assembled instruction word (held between writes)
//   ADDRESS        instruction-memory word address (held between writes)
//   R_EN           core run enable, high only after a verified load
//   BUSY/DONE/ERR  status: loading / verified load complete / load failed
//
//   Every output is either a register or a decode of the state register, so
//   there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int unsigned ADDRESS_BITS = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [7:0]            RX_DATA,
  input  logic                  RX_VALID,
  output logic                  RX_READY,
  output logic                  W_EN,
  output logic [31:0]           W_INSTRUCTION,
  output logic [ADDRESS_BITS:0] ADDRESS,
  output logic                  R_EN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int unsigned AW    = ADDRESS_BITS + 1;
  localparam int unsigned WORDS = 1 << AW;
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_RUN,
    S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   word_idx_q, word_idx_d;
  logic [AW-1:0]   last_idx_q, last_idx_d;   // N-1, the final word index
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [7:0]      csum_q, csum_d;
  logic [23:0]     asm_q, asm_d;             // lanes 0..2 of the word in flight
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     winst_q, winst_d;

  logic            rx_ready;
  logic            accept;
  logic            count_bad;

  // ---------------------------------------------------------------------------
  // Output decode (state register only)
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_ready = (state_q == S_COUNT) || (state_q == S_DATA) || (state_q == S_CHECK);
  end

  assign RX_READY      = rx_ready;
  assign W_EN          = (state_q == S_WRITE);
  assign R_EN          = (state_q == S_RUN);
  assign DONE          = (state_q == S_RUN);
  assign ERR           = (state_q == S_FAIL);
  assign BUSY          = (state_q == S_COUNT) || (state_q == S_DATA) ||
                         (state_q == S_WRITE) || (state_q == S_CHECK);
  assign ADDRESS       = addr_q;
  assign W_INSTRUCTION = winst_q;

  assign accept    = RX_VALID & rx_ready;
  assign count_bad = (RX_DATA == 8'd0) || (32'(RX_DATA) > WORDS);

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    last_idx_d = last_idx_q;
    byte_idx_d = byte_idx_q;
    csum_d     = csum_q;
    asm_d      = asm_q;
    addr_d     = addr_q;
    winst_d    = winst_q;

    unique case (state_q)
      S_IDLE, S_RUN, S_FAIL: begin
        if (START) begin
          state_d    = S_COUNT;
          word_idx_d = '0;
          byte_idx_d = '0;
          csum_d     = '0;
        end
      end

      S_COUNT: begin
        if (accept) begin
          if (count_bad) begin
            state_d = S_FAIL;
          end else begin
            last_idx_d = AW'(RX_DATA - 8'd1);
            state_d    = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ RX_DATA;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: asm_d[7:0]   = RX_DATA;
            2'd1: asm_d[15:8]  = RX_DATA;
            2'd2: asm_d[23:16] = RX_DATA;
            default: begin
              // Last lane goes straight into the output word so that
              // W_INSTRUCTION/ADDRESS are already valid in the WRITE cycle.
              winst_d = {RX_DATA, asm_q};
              addr_d  = word_idx_q;
              state_d = S_WRITE;
            end
          endcase
        end
      end

      S_WRITE: begin
        if (word_idx_q == last_idx_q) begin
          state_d = S_CHECK;
        end else begin
          word_idx_d = word_idx_q + IDX_ONE;
          state_d    = S_DATA;
        end
      end

      S_CHECK: begin
        if (accept) begin
          state_d = (RX_DATA == csum_q) ? S_RUN : S_FAIL;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      word_idx_q <= '0;
      last_idx_q <= '0;
      byte_idx_q <= '0;
      csum_q     <= '0;
      asm_q      <= '0;
      addr_q     <= '0;
      winst_q    <= '0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      last_idx_q <= last_idx_d;
      byte_idx_q <= byte_idx_d;
      csum_q     <= csum_d;
      asm_q      <= asm_d;
      addr_q     <= addr_d;
      winst_q    <= winst_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//   Directed bench for program_loader (ADDRESS_BITS = 4, 32 words).
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_program_loader;

  localparam int unsigned AB = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic [7:0]    RX_DATA;
  logic          RX_VALID;
  logic          RX_READY;
  logic          W_EN;
  logic [31:0]   W_INSTRUCTION;
  logic [AB:0]   ADDRESS;
  logic          R_EN;
  logic          BUSY;
  logic          DONE;
  logic          ERR;

  program_loader #(.ADDRESS_BITS(AB)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .START         (START),
    .RX_DATA       (RX_DATA),
    .RX_VALID      (RX_VALID),
    .RX_READY      (RX_READY),
    .W_EN          (W_EN),
    .W_INSTRUCTION (W_INSTRUCTION),
    .ADDRESS       (ADDRESS),
    .R_EN          (R_EN),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .ERR           (ERR)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [AB:0]  wr_addr[$];
  logic [31:0]  wr_data[$];
  int           wr_cyc[$];
  logic [7:0]   stream[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Write monitor: records every strobe; the core must never run while writing.
  always @(negedge CLK) begin
    if (W_EN === 1'b1) begin
      wr_addr.push_back(ADDRESS);
      wr_data.push_back(W_INSTRUCTION);
      wr_cyc.push_back(cyc);
      check_eq("r_en_during_w_en", {31'b0, R_EN}, 32'd0);
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_wr();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic check_status(input string tag, input logic r, input logic d,
                              input logic b, input logic e, input logic rdy);
    check_eq({tag, ".r_en"},     {31'b0, R_EN},     {31'b0, r});
    check_eq({tag, ".done"},     {31'b0, DONE},     {31'b0, d});
    check_eq({tag, ".busy"},     {31'b0, BUSY},     {31'b0, b});
    check_eq({tag, ".err"},      {31'b0, ERR},      {31'b0, e});
    check_eq({tag, ".rx_ready"}, {31'b0, RX_READY}, {31'b0, rdy});
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    bit acc;
    acc      = 1'b0;
    RX_VALID = 1'b1;
    RX_DATA  = b;
    for (int k = 0; k < 40 && !acc; k++) begin
      if (RX_READY === 1'b1) acc = 1'b1;
      @(negedge CLK);
    end
    check_eq("rx_accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic send_stream();
    foreach (stream[i]) send_byte(stream[i]);
    RX_VALID = 1'b0;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic check_write(input string tag, input int idx,
                             input logic [AB:0] a, input logic [31:0] d);
    if (wr_addr.size() > idx) begin
      check_eq({tag, ".addr"}, {27'b0, wr_addr[idx]}, {27'b0, a});
      check_eq({tag, ".data"}, wr_data[idx], d);
    end
  endtask

  logic [7:0]  cs;
  logic [7:0]  bt;
  logic [31:0] exp_w;

  initial begin
    RST      = 1'b1;
    START    = 1'b0;
    RX_VALID = 1'b0;
    RX_DATA  = 8'h00;
    repeat (3) @(negedge CLK);

    // ---- reset state
    check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("reset.w_en",  {31'b0, W_EN}, 32'd0);
    check_eq("reset.addr",  {27'b0, ADDRESS}, 32'd0);
    check_eq("reset.winst", W_INSTRUCTION, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    check_status("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // ---- single word load: 01 | 13 00 00 00 | 13
    clear_wr();
    pulse_start();
    check_status("one.count", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    stream = '{8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    send_stream();
    check_eq("one.nwrites", wr_addr.size(), 32'd1);
    check_write("one.w0", 0, 5'd0, 32'h0000_0013);
    check_status("one.run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("one.addr_hold",  {27'b0, ADDRESS}, 32'd0);
    check_eq("one.winst_hold", W_INSTRUCTION, 32'h0000_0013);
    RX_VALID = 1'b1;
    RX_DATA  = 8'h5A;
    repeat (2) @(negedge CLK);
    check_status("one.run_offer", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    RX_VALID = 1'b0;

    // ---- restart from RUN, two words, good checksum 0x71
    clear_wr();
    pulse_start();
    check_status("two.restart", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    stream = '{8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
    send_stream();
    check_eq("two.nwrites", wr_addr.size(), 32'd2);
    check_write("two.w0", 0, 5'd0, 32'h0050_0093);
    check_write("two.w1", 1, 5'd1, 32'h00A0_0113);
    if (wr_cyc.size() == 2) check_eq("two.spacing", wr_cyc[1] - wr_cyc[0], 32'd5);
    check_status("two.run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // ---- same program, checksum corrupted (0x71 ^ 0xFF = 0x8E)
    clear_wr();
    pulse_start();
    stream = '{8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h8E};
    send_stream();
    check_eq("badcs.nwrites", wr_addr.size(), 32'd2);
    check_status("badcs.fail", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("badcs.winst_hold", W_INSTRUCTION, 32'h00A0_0113);

    // ---- count byte 0x00 (from FAIL), then 0x21
    clear_wr();
    pulse_start();
    check_status("cnt0.restart", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_byte(8'h00);
    RX_VALID = 1'b0;
    check_status("cnt0.fail", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_start();
    send_byte(8'h21);
    RX_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    check_status("cnt21.fail", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("cnt.nwrites", wr_addr.size(), 32'd0);

    // ---- full 32-word load, RX_VALID held high throughout
    clear_wr();
    pulse_start();
    stream.delete();
    stream.push_back(8'h20);
    cs = 8'h00;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) begin
        bt = 8'((4 * i + j) ^ 8'hC3);
        stream.push_back(bt);
        cs = cs ^ bt;
      end
    end
    stream.push_back(cs);
    send_stream();
    check_eq("full.nwrites", wr_addr.size(), 32'd32);
    for (int i = 0; i < 32; i++) begin
      exp_w = '0;
      for (int j = 0; j < 4; j++) begin
        bt = 8'((4 * i + j) ^ 8'hC3);
        exp_w[8*j +: 8] = bt;
      end
      check_write($sformatf("full.w%0d", i), i, 5'(i), exp_w);
      if (i > 0 && wr_cyc.size() > i)
        check_eq($sformatf("full.spacing%0d", i), wr_cyc[i] - wr_cyc[i-1], 32'd5);
    end
    check_status("full.run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // ---- 3-word load: START during DATA ignored, RST after two words
    clear_wr();
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    RX_VALID = 1'b0;
    START    = 1'b1;
    @(negedge CLK);
    START    = 1'b0;
    check_status("mid.start_ignored", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_byte(8'h77); send_byte(8'h88);
    RX_VALID = 1'b0;
    @(negedge CLK);
    check_eq("mid.nwrites", wr_addr.size(), 32'd2);
    check_write("mid.w0", 0, 5'd0, 32'h4433_2211);
    check_write("mid.w1", 1, 5'd1, 32'h8877_6655);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_status("mid.rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("mid.rst.addr",  {27'b0, ADDRESS}, 32'd0);
    check_eq("mid.rst.winst", W_INSTRUCTION, 32'd0);
    RX_VALID = 1'b1;
    RX_DATA  = 8'h99;
    repeat (6) @(negedge CLK);
    RX_VALID = 1'b0;
    check_status("mid.after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("mid.after_rst.nwrites", wr_addr.size(), 32'd2);

    // ---- RST has priority over START
    RST   = 1'b1;
    START = 1'b1;
    @(negedge CLK);
    RST   = 1'b0;
    START = 1'b0;
    check_status("rst_prio", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
